key_debouncer: RTL

Multi-channel push-button conditioner feeding the recorder/player top level. It converts raw asynchronous active-low board keys into the clean single-cycle `key down` pulses that drive record, play and pause control (`i_key_0..2`), plus release pulses and debounced levels. Each channel has its own synchroniser, debounce counter and state machine. Long-press detection is compile-time optional.

---
 rtl/key_pkg.sv | 16 +
 rtl/key_debounce_ch.sv | 159 +++++++++++++++
 rtl/key_debouncer.sv | 42 ++++
 3 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and 12 MHz default timing for key_debouncer.
// Long-press support is selected at compile time with KEY_LONGPRESS_EN.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } key_state_e;

  localparam int DEF_NUM_KEYS        = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 50_000;
  localparam int DEF_LONG_CYCLES     = 6_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel - synchroniser, counter, FSM, pulses.
// Long-press logic exists only when KEY_LONGPRESS_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_LONGPRESS_EN
  ,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_down,
  output logic o_up,
  output logic o_level,
  output logic o_long
);

`ifdef KEY_LONGPRESS_EN
  localparam int CNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`else
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
`endif
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             down_q, down_d;
  logic             up_q, up_d;
  logic             level_q, level_d;
  logic             pressed;

`ifdef KEY_LONGPRESS_EN
  logic long_q, long_d;
  logic fired_q, fired_d;
`endif

  assign pressed = ~sync_q[1];

  // Two-stage synchroniser input shift.
  always_comb begin
    sync_d = {sync_q[0], i_key_n};
  end

  // Synchroniser flops; reset to released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= 2'b11;
    else          sync_q <= sync_d;
  end

  // Next state, counter and pulse generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    down_d  = 1'b0;
    up_d    = 1'b0;
    level_d = level_q;
`ifdef KEY_LONGPRESS_EN
    long_d  = 1'b0;
    fired_d = fired_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          down_d  = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
`ifdef KEY_LONGPRESS_EN
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (cnt_q == LONG_LAST && !fired_q) begin
            long_d  = 1'b1;
            fired_d = 1'b1;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          up_d    = 1'b1;
          level_d = 1'b0;
`ifdef KEY_LONGPRESS_EN
          fired_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      down_q  <= down_d;
      up_q    <= up_d;
      level_q <= level_d;
    end
  end

`ifdef KEY_LONGPRESS_EN
  // Long-press pulse and its once-per-hold flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      long_q  <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      long_q  <= long_d;
      fired_q <= fired_d;
    end
  end

  assign o_long = long_q;
`else
  assign o_long = 1'b0;
`endif

  assign o_down  = down_q;
  assign o_up    = up_q;
  assign o_level = level_q;

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: NUM_KEYS independent debounce channels for board keys.
// Define KEY_LONGPRESS_EN to build the long-press pulse outputs.
module key_debouncer
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_key_n,
  output logic [NUM_KEYS-1:0] o_key_down,
  output logic [NUM_KEYS-1:0] o_key_up,
  output logic [NUM_KEYS-1:0] o_key_level,
  output logic [NUM_KEYS-1:0] o_key_long
);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES)
  begin : g_bad_params
    $error("key_debouncer: need DEBOUNCE_CYCLES>=2, LONG>DEBOUNCE");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_LONGPRESS_EN
      ,
      .LONG_CYCLES(LONG_CYCLES)
`endif
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_key_n (i_key_n[i]),
      .o_down  (o_key_down[i]),
      .o_up    (o_key_up[i]),
      .o_level (o_key_level[i]),
      .o_long  (o_key_long[i])
    );
  end

endmodule
